// File: rtl/normalize_shifter.sv
// ============================================================================
// normalize_shifter: post-normalization stage of the FP adder (LOD consumer).
// Two-stage encode + shift/adjust with zero/underflow/overflow flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module normalize_shifter #(
  parameter int DATA_WIDTH  = 49,
  parameter int EXP_WIDTH   = 11,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in_onehot,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic                  out_sticky,
  output logic                  out_zero,
  output logic                  out_underflow,
  output logic                  out_overflow
);

  localparam logic [EXP_WIDTH:0] c_EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};
  localparam logic [EXP_WIDTH:0] c_ONE     = {{EXP_WIDTH{1'b0}}, 1'b1};

  logic                   w_enc_zero;
  logic                   w_enc_right;
  logic [SHIFT_WIDTH-1:0] w_enc_amt;

  logic                   r1_valid;
  logic                   r1_zero;
  logic                   r1_right;
  logic [SHIFT_WIDTH-1:0] r1_amt;
  logic [DATA_WIDTH-1:0]  r1_data;
  logic [EXP_WIDTH-1:0]   r1_exp;

  logic [EXP_WIDTH:0]     w_exp_ext;
  logic [EXP_WIDTH:0]     w_amt_ext;
  logic [EXP_WIDTH:0]     w_exp_inc;
  logic [EXP_WIDTH:0]     w_exp_dec;
  logic                   w_left_uf;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [EXP_WIDTH-1:0]   w_exp;
  logic                   w_sticky;
  logic                   w_zero;
  logic                   w_uf;
  logic                   w_ovf;

  logic                   r2_valid;
  logic [DATA_WIDTH-1:0]  r2_data;
  logic [EXP_WIDTH-1:0]   r2_exp;
  logic                   r2_sticky;
  logic                   r2_zero;
  logic                   r2_uf;
  logic                   r2_ovf;

  // Ascending scan so the highest set bit wins even for a non-one-hot vector.
  always_comb begin
    w_enc_zero  = 1'b1;
    w_enc_right = 1'b0;
    w_enc_amt   = '0;
    for (int i = 0; i < DATA_WIDTH - 1; i++) begin
      if (in_onehot[i]) begin
        w_enc_zero = 1'b0;
        w_enc_amt  = SHIFT_WIDTH'(DATA_WIDTH - 2 - i);
      end
    end
    if (in_onehot[DATA_WIDTH-1]) begin
      w_enc_zero  = 1'b0;
      w_enc_right = 1'b1;
      w_enc_amt   = SHIFT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_valid <= 1'b0;
      r1_zero  <= 1'b0;
      r1_right <= 1'b0;
      r1_amt   <= '0;
      r1_data  <= '0;
      r1_exp   <= '0;
    end else begin
      r1_valid <= valid_in;
      if (valid_in) begin
        r1_zero  <= w_enc_zero;
        r1_right <= w_enc_right;
        r1_amt   <= w_enc_amt;
        r1_data  <= in_data;
        r1_exp   <= in_exp;
      end
    end
  end

  assign w_exp_ext = {1'b0, r1_exp};
  assign w_amt_ext = {{(EXP_WIDTH + 1 - SHIFT_WIDTH){1'b0}}, r1_amt};
  assign w_exp_inc = w_exp_ext + c_ONE;
  assign w_exp_dec = w_exp_ext - w_amt_ext;
  // Borrow or an exact-zero result both mean exp <= amt.
  assign w_left_uf = w_exp_dec[EXP_WIDTH] | (w_exp_dec[EXP_WIDTH-1:0] == '0);

  always_comb begin
    w_data   = r1_data;
    w_exp    = r1_exp;
    w_sticky = 1'b0;
    w_zero   = 1'b0;
    w_uf     = 1'b0;
    w_ovf    = 1'b0;
    if (r1_zero) begin
      w_data = '0;
      w_exp  = '0;
      w_zero = 1'b1;
    end else if (r1_right) begin
      w_data   = r1_data >> 1;
      w_sticky = r1_data[0];
      if (w_exp_inc >= c_EXP_MAX) begin
        w_ovf  = 1'b1;
        w_exp  = '1;
        w_data = '0;
      end else begin
        w_exp = w_exp_inc[EXP_WIDTH-1:0];
      end
    end else if (w_left_uf) begin
      w_uf   = 1'b1;
      w_zero = 1'b1;
      w_data = '0;
      w_exp  = '0;
    end else begin
      w_data = r1_data << r1_amt;
      w_exp  = w_exp_dec[EXP_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_valid  <= 1'b0;
      r2_data   <= '0;
      r2_exp    <= '0;
      r2_sticky <= 1'b0;
      r2_zero   <= 1'b0;
      r2_uf     <= 1'b0;
      r2_ovf    <= 1'b0;
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_data   <= w_data;
        r2_exp    <= w_exp;
        r2_sticky <= w_sticky;
        r2_zero   <= w_zero;
        r2_uf     <= w_uf;
        r2_ovf    <= w_ovf;
      end
    end
  end

  assign valid_out     = r2_valid;
  assign out_data      = r2_data;
  assign out_exp       = r2_exp;
  assign out_sticky    = r2_sticky;
  assign out_zero      = r2_zero;
  assign out_underflow = r2_uf;
  assign out_overflow  = r2_ovf;

endmodule

`default_nettype wire

// File: tb/tb_normalize_shifter.sv
// ============================================================================
// tb_normalize_shifter: directed vectors with hand-computed expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_normalize_shifter;

  localparam int DW = 49;
  localparam int EW = 11;

  logic          clk;
  logic          rstn;
  logic          valid_in;
  logic [DW-1:0] in_onehot;
  logic [DW-1:0] in_data;
  logic [EW-1:0] in_exp;
  logic          valid_out;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exp;
  logic          out_sticky;
  logic          out_zero;
  logic          out_underflow;
  logic          out_overflow;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [DW-1:0] oh;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic [DW-1:0] xd;
    logic [EW-1:0] xe;
    logic          xs;
    logic          xz;
    logic          xu;
    logic          xo;
  } vec_t;

  vec_t v[10];

  normalize_shifter #(
    .DATA_WIDTH (DW),
    .EXP_WIDTH  (EW),
    .SHIFT_WIDTH(6)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .valid_in     (valid_in),
    .in_onehot    (in_onehot),
    .in_data      (in_data),
    .in_exp       (in_exp),
    .valid_out    (valid_out),
    .out_data     (out_data),
    .out_exp      (out_exp),
    .out_sticky   (out_sticky),
    .out_zero     (out_zero),
    .out_underflow(out_underflow),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_res(input string tag, input int i);
    chk($sformatf("%s_data", tag), 64'(out_data), 64'(v[i].xd));
    chk($sformatf("%s_exp", tag), 64'(out_exp), 64'(v[i].xe));
    chk($sformatf("%s_flags", tag),
        64'({out_sticky, out_zero, out_underflow, out_overflow}),
        64'({v[i].xs, v[i].xz, v[i].xu, v[i].xo}));
  endtask

  task automatic drive(input int i);
    valid_in  = 1'b1;
    in_onehot = v[i].oh;
    in_data   = v[i].d;
    in_exp    = v[i].e;
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    in_onehot = DW'({$urandom(), $urandom()});
    in_data   = DW'({$urandom(), $urandom()});
    in_exp    = EW'($urandom());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int i);
    drive(i);
    step();
    idle();
    chk($sformatf("v%0d_lat1", i), 64'(valid_out), 64'd0);
    step();
    chk($sformatf("v%0d_valid", i), 64'(valid_out), 64'd1);
    check_res($sformatf("v%0d", i), i);
    step();
    chk($sformatf("v%0d_vdrop", i), 64'(valid_out), 64'd0);
    check_res($sformatf("v%0d_hold", i), i);
  endtask

  task automatic set_vec(input int i, input logic [DW-1:0] oh, input logic [DW-1:0] d,
                         input logic [EW-1:0] e, input logic [DW-1:0] xd,
                         input logic [EW-1:0] xe, input logic [3:0] szuo);
    v[i].oh = oh;
    v[i].d  = d;
    v[i].e  = e;
    v[i].xd = xd;
    v[i].xe = xe;
    {v[i].xs, v[i].xz, v[i].xu, v[i].xo} = szuo;
  endtask

  initial begin
    logic [DW-1:0] b48, b47, b40;
    b48 = DW'(1) << 48;
    b47 = DW'(1) << 47;
    b40 = DW'(1) << 40;
    set_vec(0, b48, b48 | DW'(1), 11'd1023, b47, 11'd1024, 4'b1000);
    set_vec(1, b40, b40, 11'd1023, b47, 11'd1016, 4'b0000);
    set_vec(2, b47, b47 | DW'(5), 11'd500, b47 | DW'(5), 11'd500, 4'b0000);
    set_vec(3, '0, '0, 11'd77, '0, 11'd0, 4'b0100);
    set_vec(4, DW'(1), DW'(1), 11'd20, '0, 11'd0, 4'b0110);
    set_vec(5, b48, b48, 11'd2046, '0, 11'd2047, 4'b0001);
    set_vec(6, b40, b40 | DW'(3), 11'd8, b47 | (DW'(3) << 7), 11'd1, 4'b0000);
    set_vec(7, b40, b40, 11'd7, '0, 11'd0, 4'b0110);
    set_vec(8, (DW'(1) << 30) | (DW'(1) << 5), (DW'(1) << 30) | DW'(1), 11'd100,
            b47 | (DW'(1) << 17), 11'd83, 4'b0000);
    set_vec(9, b48, b48 | (DW'(1) << 10), 11'd2045, b47 | (DW'(1) << 9), 11'd2046, 4'b0000);

    rstn = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      step();
      chk($sformatf("rst%0d_valid", k), 64'(valid_out), 64'd0);
      chk($sformatf("rst%0d_data", k), 64'(out_data), 64'd0);
      chk($sformatf("rst%0d_exp", k), 64'(out_exp), 64'd0);
      chk($sformatf("rst%0d_flags", k),
          64'({out_sticky, out_zero, out_underflow, out_overflow}), 64'd0);
      idle();
    end
    rstn = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_one(i);

    // Back-to-back: output after iteration k belongs to vector k-1.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(k);
      else idle();
      step();
      if (k >= 1 && k <= 8) begin
        chk($sformatf("tp%0d_valid", k - 1), 64'(valid_out), 64'd1);
        check_res($sformatf("tp%0d", k - 1), k - 1);
      end else if (k >= 9) begin
        chk($sformatf("tp_hold%0d_valid", k), 64'(valid_out), 64'd0);
        check_res($sformatf("tp_hold%0d", k), 7);
      end
    end

    drive(1);
    step();
    drive(2);
    step();
    rstn = 1'b0;
    idle();
    #1;
    chk("mrst_valid", 64'(valid_out), 64'd0);
    chk("mrst_data", 64'(out_data), 64'd0);
    step();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mrst_drop%0d", k), 64'(valid_out), 64'd0);
    end
    run_one(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/normalize_shifter.md
Name: normalize_shifter

Overview:
- Post-normalization stage of the floating-point adder; consumer side of the leading-one detector interface.
- Inputs: the one-hot leading-one vector from the detector, the matching unnormalized mantissa sum, and the pre-normalization exponent.
- Function: encodes the one-hot vector into a shift amount, shifts the mantissa so the leading one lands at bit DATA_WIDTH-2, and adjusts the exponent.
- Flags zero, underflow and overflow. Two-stage pipeline, valid-only flow control.

Parameters:
DATA_WIDTH, 49, mantissa sum width; bit DATA_WIDTH-1 is adder carry-out, normalized leading-one position is DATA_WIDTH-2
EXP_WIDTH, 11, biased exponent width
SHIFT_WIDTH, 6, shift-amount width; must satisfy 2^SHIFT_WIDTH > DATA_WIDTH-2

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
valid_in  input  1  input qualifier, one transaction per cycle, no backpressure
in_onehot  input  DATA_WIDTH  leading-one vector, one-hot or all-zero
in_data  input  DATA_WIDTH  unnormalized mantissa sum
in_exp  input  EXP_WIDTH  exponent before normalization
valid_out  output  1  output qualifier
out_data  output  DATA_WIDTH  normalized mantissa
out_exp  output  EXP_WIDTH  adjusted exponent
out_sticky  output  1  bit lost by a right shift
out_zero  output  1  result is zero
out_underflow  output  1  exponent underflow, result flushed to zero
out_overflow  output  1  exponent overflow, result forced to infinity

Behaviour:
- Reset and sync: one clock (clk); reset is asynchronous, active-low (rstn).
- While rstn=0: all pipeline registers and all outputs are 0.
- Reset asserted mid-operation discards in-flight transactions; the first valid_out follows 2 cycles after the first valid_in accepted after release.
- Latency: exactly 2 cycles, valid_in at edge N gives valid_out at edge N+2. Full throughput, back-to-back valids.
- valid_out is a pure 2-stage delay of valid_in.
- A data register loads only when its stage valid is 1; otherwise it holds its previous value.
- Stage 1 (encode), priority on the highest set bit of in_onehot (defined even for a non-one-hot vector):
  - Bit DATA_WIDTH-1 set: dir=right, amt=1.
  - Bit p set, p<=DATA_WIDTH-2: dir=left, amt=DATA_WIDTH-2-p.
  - All zero: zero=1.
  - Register dir, amt, zero, in_data and in_exp.
- Stage 2 (shift/adjust), unsigned arithmetic with a width of EXP_WIDTH+1 to detect borrow/carry:
  - zero: out_data=0, out_exp=0, out_zero=1; other flags 0.
  - right:
    - out_data = data>>1, out_sticky = data[0], exp_new = exp+1.
    - If exp_new >= 2^EXP_WIDTH-1: out_overflow=1, out_exp = all ones, out_data=0.
  - left:
    - exp_new = exp-amt.
    - If exp <= amt: out_underflow=1, out_zero=1, out_data=0, out_exp=0.
    - Otherwise out_data = data<<amt, out_exp = exp_new.
  - amt=0 (already normalized): data and exp pass unchanged.
  - out_sticky=0 on every non-right path.
- Flags are mutually exclusive except underflow, which implies out_zero.
- Each flag is registered with its transaction and held with the data when no valid arrives.
- in_onehot is trusted. No check of in_onehot against in_data is performed.

Test Plan:
- Reset (rstn=0 for 3 cycles, random inputs with valid_in=1) -> all outputs 0. After release, first valid_out appears 2 cycles after the first valid_in.
- Carry case (in_data=1<<48|1, in_onehot=1<<48, in_exp=1023) -> out_data=1<<47, out_exp=1024, out_sticky=1, flags 0.
- Left shift (in_data=1<<40, in_onehot=1<<40, in_exp=1023) -> out_data=1<<47, out_exp=1016. Also in_onehot=1<<47, exp 500 -> out_data=1<<47, exp unchanged 500.
- Zero and underflow:
  - in_onehot=0, in_data=0 -> out_zero=1, out_exp=0.
  - in_data=1, in_onehot=1, in_exp=20 (amt 47) -> out_underflow=1, out_zero=1, out_data=0.
- Overflow (in_onehot=1<<48, in_exp=2046) -> out_overflow=1, out_exp=2047, out_data=0.
- Throughput/hold:
  - 8 back-to-back valids with mixed cases -> 8 consecutive valid_out cycles, results in order.
  - Then valid_in=0 -> valid_out=0 after 2 cycles, out_data/out_exp/flags hold the last result.
  - rstn pulse mid-stream -> in-flight results dropped.
